lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Parametrised load/store unit between the core's memory stage and a single-port data memory bus with a valid/ready handshake. It replaces the combinational byte-enable, read-extend and write-align path with a sequential engine. Supports byte, halfword and full-word accesses with signed or unsigned load extension. Accesses that cross a bus-word boundary are split into two bus beats automatically. Sits after the ALU address result in the multicycle/pipelined core; the core sees one request and one response per access.

## Interface
- DATA_W, 32: bus and register data width in bits; power of two, ≥16. BYTES = DATA_W/8.
- ADDR_W, 32: byte-address width.

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  LSU accepts request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word (BYTES); 11 treated as 10
- req_signed  in  1  sign-extend load result (ignored for stores and word loads)
- req_addr  in  ADDR_W  byte address, any alignment
- req_wdata  in  DATA_W  store data, right-aligned
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  DATA_W  extended load data (0 for stores)
- mem_valid  out  1  bus beat request
- mem_ready  in  1  bus accepts beat; for reads, mem_rdata valid in same cycle
- mem_write  out  1  beat is a write
- mem_addr  out  ADDR_W  bus-word-aligned address (low log2(BYTES) bits 0)
- mem_be  out  BYTES  byte-lane enables, little-endian
- mem_wdata  out  DATA_W  lane-aligned write data
- mem_rdata  in  DATA_W  read data

## Operation
- FSM: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. On req_valid: capture write/size/signed/addr/wdata, go BEAT0.
- BEAT0: mem_valid=1. On mem_ready: if split go BEAT1, else RESP.
- BEAT1: mem_valid=1 for the second beat. On mem_ready go RESP.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. The core gives no backpressure.
- off = addr mod BYTES; n = 1, 2 or BYTES; split = (off + n > BYTES).
- Beat0: mem_addr = addr with low bits cleared; mem_be = lanes off..min(BYTES-1, off+n-1).
- Beat1: mem_addr = beat0 address + BYTES, wrapping modulo 2^ADDR_W; mem_be = lanes 0..(off+n-1-BYTES).
- mem_wdata on both beats = req_wdata rotated left by 8·off bits. Bytes on disabled lanes are don't-care.
- Loads:
  - Sample the enabled lanes of mem_rdata into a staging register on each accepted read beat.
  - Result = staging rotated right by 8·off, masked to n bytes, then sign- or zero-extended.
  - rsp_rdata is registered and holds its value until the next RESP.
- Stores: rsp_rdata = 0 at RESP.

## Timing
- Reset values: state IDLE, req_ready=1, mem_valid=0, mem_be=0, mem_write=0, rsp_valid=0, rsp_rdata=0, staging=0.
- Reset is asynchronous: mem_valid and rsp_valid drop without waiting for a clock edge. An in-flight access is abandoned with no response.
- Latency with mem_ready tied high (request accepted at edge 0):
  - mem_valid is high in cycle 1.
  - rsp_valid is high in cycle 2 for an unsplit access, cycle 3 for a split one.
  - Each cycle mem_ready is low adds one cycle.
- While mem_valid=1 and mem_ready=0: mem_addr, mem_be, mem_write and mem_wdata are held stable.
- req_ready=0 in BEAT0, BEAT1 and RESP. The next request can be accepted in the cycle after RESP.
- All outputs are driven from registered state; there is no combinational path from req_* to mem_*.

## Test plan (DATA_W=32, mem_ready=1 unless stated)
- Word load, addr 0x100, mem_rdata 0xDEADBEEF -> one beat, mem_addr 0x100, be 1111; rsp_valid in cycle 2, rsp_rdata 0xDEADBEEF.
- Byte load, addr 0x103, mem_rdata 0x80123456:
  - signed -> be 1000, rsp_rdata 0xFFFFFF80
  - unsigned -> rsp_rdata 0x00000080
- Half store, addr 0x102, wdata 0x0000ABCD -> single beat, mem_write=1, be 1100, mem_wdata[31:16]=0xABCD; rsp_rdata 0.
- Split word load, addr 0x106:
  - beat0: addr 0x104, be 1100, rdata 0xBBAA0000
  - beat1: addr 0x108, be 0011, rdata 0x0000DDCC
  - -> rsp_rdata 0xDDCCBBAA in cycle 3.
- Wrapping split half store, addr 0xFFFFFFFF, wdata 0x1234:
  - beat0: addr 0xFFFFFFFC, be 1000, lane3=0x34
  - beat1: addr 0x00000000, be 0001, lane0=0x12
- Hold then reset, split load: mem_ready low 5 cycles in BEAT0 -> mem_addr/mem_be stable throughout. Assert reset mid-BEAT1 -> mem_valid=0 immediately, req_ready=1 after release, no rsp_valid. The next aligned load completes normally.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store engine between the core memory stage and a single-port valid/ready data bus.
// Unaligned accesses that straddle a bus word are issued as two beats; every output is registered.
module lsu_mem_port #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic                  req_signed,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic                  mem_write,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int CNT_W = OFF_W + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1, ST_RESP} state_e;

   // Byte-granular rotation; left moves byte i to lane i+sh.
   function automatic logic [DATA_W-1:0] rot_bytes(input logic [DATA_W-1:0] d,
                                                   input logic [OFF_W-1:0]  sh,
                                                   input logic              left);
      logic [DATA_W-1:0] r;
      logic [OFF_W-1:0]  src;
      r = '0;
      for (int i = 0; i < BYTES; i++) begin
         src = left ? (OFF_W'(i) - sh) : (OFF_W'(i) + sh);
         r[8*i +: 8] = d[8*src +: 8];
      end
      return r;
   endfunction

   // Lane enables across two consecutive bus words: low half is beat 0, high half beat 1.
   function automatic logic [2*BYTES-1:0] lane_mask(input logic [OFF_W-1:0] off,
                                                    input logic [CNT_W-1:0] n);
      logic [2*BYTES-1:0] m;
      int o;
      int nn;
      o  = int'(off);
      nn = int'(n);
      m  = '0;
      for (int j = 0; j < 2*BYTES; j++) begin
         m[j] = (j >= o) && (j < o + nn);
      end
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] expand_be(input logic [BYTES-1:0] be);
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < BYTES; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                input logic [CNT_W-1:0]  n,
                                                input logic              sgn);
      logic [DATA_W-1:0] r;
      logic              sb;
      int                nb;
      nb = int'(n);
      sb = sgn && (nb < BYTES) && d[8*nb-1];
      r  = '0;
      for (int i = 0; i < BYTES; i++) begin
         r[8*i +: 8] = (i < nb) ? d[8*i +: 8] : {8{sb}};
      end
      return r;
   endfunction

   state_e               state_q;
   logic                 req_ready_q;
   logic                 mem_valid_q;
   logic                 mem_write_q;
   logic [ADDR_W-1:0]    mem_addr_q;
   logic [BYTES-1:0]     mem_be_q;
   logic [BYTES-1:0]     be1_q;
   logic [DATA_W-1:0]    mem_wdata_q;
   logic [OFF_W-1:0]     off_q;
   logic [CNT_W-1:0]     n_q;
   logic                 signed_q;
   logic [DATA_W-1:0]    staging_q;
   logic [DATA_W-1:0]    staging_d;
   logic                 rsp_valid_q;
   logic [DATA_W-1:0]    rsp_rdata_q;

   logic [OFF_W-1:0]     req_off;
   logic [CNT_W-1:0]     req_n;
   logic [2*BYTES-1:0]   req_mask;
   logic [DATA_W-1:0]    load_result;

   // Request decode and load-result assembly from the staging register including the current beat.
   always_comb begin
      req_off = req_addr[OFF_W-1:0];
      case (req_size)
         2'b00:   req_n = CNT_W'(1);
         2'b01:   req_n = CNT_W'(2);
         default: req_n = CNT_W'(BYTES);
      endcase
      req_mask    = lane_mask(req_off, req_n);
      staging_d   = (staging_q & ~expand_be(mem_be_q)) | (mem_rdata & expand_be(mem_be_q));
      load_result = extend(rot_bytes(staging_d, off_q, 1'b0), n_q, signed_q);
   end

   // Access sequencer: IDLE -> BEAT0 [-> BEAT1] -> RESP, all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         req_ready_q <= 1'b1;
         mem_valid_q <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         be1_q       <= '0;
         mem_wdata_q <= '0;
         off_q       <= '0;
         n_q         <= '0;
         signed_q    <= 1'b0;
         staging_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  state_q     <= ST_BEAT0;
                  req_ready_q <= 1'b0;
                  mem_valid_q <= 1'b1;
                  mem_write_q <= req_write;
                  mem_addr_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  mem_be_q    <= req_mask[BYTES-1:0];
                  be1_q       <= req_mask[2*BYTES-1:BYTES];
                  mem_wdata_q <= rot_bytes(req_wdata, req_off, 1'b1);
                  off_q       <= req_off;
                  n_q         <= req_n;
                  signed_q    <= req_signed;
               end
            end
            ST_BEAT0, ST_BEAT1: begin
               if (mem_ready) begin
                  if (!mem_write_q) begin
                     staging_q <= staging_d;
                  end
                  if ((state_q == ST_BEAT0) && (|be1_q)) begin
                     state_q    <= ST_BEAT1;
                     mem_addr_q <= mem_addr_q + ADDR_W'(BYTES);
                     mem_be_q   <= be1_q;
                  end else begin
                     state_q     <= ST_RESP;
                     mem_valid_q <= 1'b0;
                     mem_write_q <= 1'b0;
                     mem_be_q    <= '0;
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= mem_write_q ? '0 : load_result;
                  end
               end
            end
            ST_RESP: begin
               state_q     <= ST_IDLE;
               rsp_valid_q <= 1'b0;
               req_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= ST_IDLE;
               req_ready_q <= 1'b1;
               mem_valid_q <= 1'b0;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_valid = mem_valid_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed cases plus random accesses against a byte-addressed memory model.
module tb_lsu_mem_port;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BY = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid, req_ready, req_write, req_signed;
   logic [1:0]    req_size;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          mem_valid, mem_ready, mem_write;
   logic [AW-1:0] mem_addr;
   logic [BY-1:0] mem_be;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   lsu_mem_port #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // bus_mem is what the DUT actually wrote; ref_mem is what the stores should have done.
   logic [7:0] bus_mem [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];

   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
   endfunction
   function automatic logic [7:0] bus_rd(input logic [31:0] a);
      return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
   endfunction
   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
      logic [31:0] r;
      int n;
      n = nbytes(sz);
      r = 32'd0;
      for (int i = 0; i < n; i++) r[8*i +: 8] = ref_rd(a + 32'(i));
      if (sg && n < 4 && r[8*n-1]) begin
         for (int i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
      end
      return r;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      for (int i = 0; i < nbytes(sz); i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         bus_mem[a + 32'(i)] = w[8*i +: 8];
         ref_mem[a + 32'(i)] = w[8*i +: 8];
      end
   endtask

   // Bus responder: ready and read data change on the falling edge only.
   logic force_low = 1'b0;
   int   stall_pct = 0;
   always @(negedge clk) begin
      mem_ready = force_low ? 1'b0 : ($urandom_range(99) >= stall_pct);
      for (int i = 0; i < BY; i++)
         mem_rdata[8*i +: 8] = mem_be[i] ? bus_rd(mem_addr + 32'(i)) : 8'($urandom);
   end

   logic [31:0] beat_addr [$];
   logic [3:0]  beat_be   [$];
   logic [31:0] beat_wd   [$];
   logic        beat_wr   [$];
   logic        hold_pend = 1'b0;
   logic [31:0] h_addr, h_wd;
   logic [3:0]  h_be;
   logic        h_wr;

   // Bus monitor: stall stability, beat log, and applying accepted write beats to bus_mem.
   always @(posedge clk) begin
      if (reset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            chk("hold_valid", 32'(mem_valid), 32'd1);
            chk("hold_addr", mem_addr, h_addr);
            chk("hold_be", 32'(mem_be), 32'(h_be));
            chk("hold_wr", 32'(mem_write), 32'(h_wr));
            chk("hold_wdata", mem_wdata, h_wd);
         end
         hold_pend = mem_valid && !mem_ready;
         h_addr = mem_addr; h_be = mem_be; h_wr = mem_write; h_wd = mem_wdata;
         if (mem_valid && mem_ready) begin
            chk("addr_align", 32'(mem_addr[1:0]), 32'd0);
            beat_addr.push_back(mem_addr);
            beat_be.push_back(mem_be);
            beat_wd.push_back(mem_wdata);
            beat_wr.push_back(mem_write);
            if (mem_write) begin
               for (int i = 0; i < BY; i++)
                  if (mem_be[i]) bus_mem[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
            end
         end
      end
   end

   task automatic do_access(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] exp;
      int          n, cyc;
      logic        spl;
      n   = nbytes(sz);
      spl = (int'(a[1:0]) + n) > 4;
      exp = w ? 32'd0 : ref_load(a, sz, sg);
      if (w) ref_store(a, sz, wd);
      beat_addr.delete(); beat_be.delete(); beat_wd.delete(); beat_wr.delete();
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom; req_size = 2'($urandom_range(3));
      chk({tag, "_mem_valid_c1"}, 32'(mem_valid), 32'd1);
      cyc = 1;
      while (rsp_valid !== 1'b1 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
      if (stall_pct == 0) chk({tag, "_latency"}, 32'(cyc), spl ? 32'd3 : 32'd2);
      chk({tag, "_beats"}, 32'(beat_addr.size()), spl ? 32'd2 : 32'd1);
      chk({tag, "_rdata"}, rsp_rdata, exp);
      if (w) begin
         for (int i = -1; i <= n; i++)
            chk({tag, "_membyte"}, 32'(bus_rd(a + 32'(i))), 32'(ref_rd(a + 32'(i))));
      end
      @(posedge clk); #1;
      chk({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic        w, sg, seen;
      logic [1:0]  sz;
      logic [31:0] a, wd;

      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; mem_ready = 1'b1; mem_rdata = 32'd0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_mem_be", 32'(mem_be), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      @(negedge clk); reset = 1'b0;

      preload(32'h100, 32'hDEADBEEF);
      do_access("wload", 1'b0, 2'b10, 1'b0, 32'h100, 32'd0);
      chk("wload_addr", beat_addr[0], 32'h100);
      chk("wload_be", 32'(beat_be[0]), 32'hF);
      chk("wload_val", rsp_rdata, 32'hDEADBEEF);

      preload(32'h100, 32'h80123456);
      do_access("bload_s", 1'b0, 2'b00, 1'b1, 32'h103, 32'd0);
      chk("bload_s_be", 32'(beat_be[0]), 32'h8);
      chk("bload_s_val", rsp_rdata, 32'hFFFFFF80);
      do_access("bload_u", 1'b0, 2'b00, 1'b0, 32'h103, 32'd0);
      chk("bload_u_val", rsp_rdata, 32'h00000080);

      do_access("hstore", 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD);
      chk("hstore_wr", 32'(beat_wr[0]), 32'd1);
      chk("hstore_be", 32'(beat_be[0]), 32'hC);
      chk("hstore_wd", 32'(beat_wd[0][31:16]), 32'hABCD);

      preload(32'h104, 32'hBBAA0000);
      preload(32'h108, 32'h0000DDCC);
      do_access("split", 1'b0, 2'b10, 1'b0, 32'h106, 32'd0);
      chk("split_a0", beat_addr[0], 32'h104);
      chk("split_be0", 32'(beat_be[0]), 32'hC);
      chk("split_a1", beat_addr[1], 32'h108);
      chk("split_be1", 32'(beat_be[1]), 32'h3);
      chk("split_val", rsp_rdata, 32'hDDCCBBAA);

      do_access("wrap", 1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h00001234);
      chk("wrap_a0", beat_addr[0], 32'hFFFFFFFC);
      chk("wrap_be0", 32'(beat_be[0]), 32'h8);
      chk("wrap_lane3", 32'(beat_wd[0][31:24]), 32'h34);
      chk("wrap_a1", beat_addr[1], 32'h00000000);
      chk("wrap_be1", 32'(beat_be[1]), 32'h1);
      chk("wrap_lane0", 32'(beat_wd[1][7:0]), 32'h12);

      // Stall five cycles in the first beat, then reset in the middle of the second.
      force_low = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h206;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("hold_b0_addr", mem_addr, 32'h204);
      chk("hold_b0_be", 32'(mem_be), 32'hC);
      repeat (5) begin
         @(posedge clk); #1;
         chk("hold_b0_valid", 32'(mem_valid), 32'd1);
         chk("hold_b0_addr_s", mem_addr, 32'h204);
         chk("hold_b0_be_s", 32'(mem_be), 32'hC);
      end
      force_low = 1'b0;
      @(posedge clk); #1;
      force_low = 1'b1;
      chk("hold_b1_addr", mem_addr, 32'h208);
      chk("hold_b1_be", 32'(mem_be), 32'h3);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      chk("arst_mem_valid", 32'(mem_valid), 32'd0);
      chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; force_low = 1'b0;
      chk("arst_req_ready", 32'(req_ready), 32'd1);
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (rsp_valid === 1'b1 || mem_valid === 1'b1) seen = 1'b1;
      end
      chk("arst_no_rsp", 32'(seen), 32'd0);

      preload(32'h300, 32'h13579BDF);
      do_access("post_rst", 1'b0, 2'b10, 1'b0, 32'h300, 32'd0);
      chk("post_rst_val", rsp_rdata, 32'h13579BDF);

      for (int k = 0; k < 160; k++) begin
         stall_pct = (k % 2 == 0) ? 0 : 40;
         w  = 1'($urandom_range(1));
         sz = 2'($urandom_range(3));
         sg = 1'($urandom_range(1));
         a  = ($urandom_range(9) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(7)))
                                       : (32'h2000 + 32'($urandom_range(31)));
         wd = $urandom;
         do_access("rnd", w, sz, sg, a, wd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
